// File: rtl/ioctrl.sv
// ioctrl: memory-mapped bus slave with an internal word RAM and a small IO
// register block (LED, synchronized switches, free-running cycle counter and
// a sticky bus-error flag).
//
// Ports
//   clk            : sole clock, all logic on the rising edge
//   reset_n        : asynchronous active-low reset
//   mem_read       : single-cycle read request pulse
//   mem_write      : single-cycle write request pulse
//   mem_addr       : byte address (bits [1:0] ignored), latched with the request
//   mem_data_write : write data, latched with the request
//   mem_ack        : registered one-cycle completion pulse
//   mem_data_read  : registered read data, holds until the next read completes
//   sw_in          : asynchronous switch inputs
//   led_out        : LED register
//   bus_err        : sticky error flag, cleared by any write to the ERR register
//
// Address map
//   addr[31]=0, addr < RAM_WORDS*4         : RAM word addr[log2(RAM_WORDS)+1:2]
//   0x8000_0000 LED (RW)  0x8000_0004 SW (RO)
//   0x8000_0008 CYCLES (RO)  0x8000_000C ERR (read flag, write clears)
//   anything else                          : unmapped, IO latency, bus_err set
module ioctrl #(
  parameter int RAM_WORDS = 1024,
  parameter int RAM_WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data_write,
  output logic        mem_ack,
  output logic [31:0] mem_data_read,
  input  logic [7:0]  sw_in,
  output logic [7:0]  led_out,
  output logic        bus_err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = 4'((RAM_WAIT > 0) ? (RAM_WAIT - 1) : 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Control state
  logic [1:0]  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_ack_q, mem_ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  led_q, led_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] cycles_q, cycles_d;
  logic [7:0]  sw_meta_q, sw_sync_q;

  // Request captured at the sampling edge; only needed while in WAIT
  logic [AW-1:0] req_idx_q, req_idx_d;
  logic [31:0]   req_wdata_q, req_wdata_d;
  logic          req_wr_q, req_wr_d;

  // Storage
  logic [31:0]   ram_q [RAM_WORDS];
  logic          ram_we;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rd;

  logic req_any;
  logic live_is_ram;
  logic live_is_io;
  logic err_set;
  logic err_clr;

  function automatic logic [31:0] io_read(input logic [1:0]  sel,
                                          input logic [7:0]  led,
                                          input logic [7:0]  sw,
                                          input logic [31:0] cyc,
                                          input logic        err);
    logic [31:0] r;
    case (sel)
      2'd0:    r = {24'b0, led};
      2'd1:    r = {24'b0, sw};
      2'd2:    r = cyc;
      default: r = {31'b0, err};
    endcase
    return r;
  endfunction

  assign req_any     = mem_read | mem_write;
  assign live_is_ram = ~mem_addr[31] && ({1'b0, mem_addr} < RAM_BYTES);
  assign live_is_io  = mem_addr[31] && (mem_addr[30:4] == 27'd0);

  // In IDLE the live bus addresses the RAM (zero-wait case); otherwise the
  // latched request does.
  assign ram_idx   = (state_q == ST_IDLE) ? mem_addr[AW+1:2] : req_idx_q;
  assign ram_wdata = (state_q == ST_IDLE) ? mem_data_write : req_wdata_q;
  assign ram_rd    = ram_q[ram_idx];

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_ack_d   = 1'b0;
    rdata_d     = rdata_q;
    led_d       = led_q;
    cycles_d    = cycles_q + 32'd1;
    req_idx_d   = req_idx_q;
    req_wdata_d = req_wdata_q;
    req_wr_d    = req_wr_q;
    ram_we      = 1'b0;
    err_set     = 1'b0;
    err_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          // Simultaneous read and write: the write proceeds, the read is lost.
          if (mem_read && mem_write) err_set = 1'b1;
          req_idx_d   = mem_addr[AW+1:2];
          req_wdata_d = mem_data_write;
          req_wr_d    = mem_write;
          if (live_is_ram) begin
            if (RAM_WAIT == 0) begin
              state_d   = ST_ACK;
              mem_ack_d = 1'b1;
              if (mem_write) ram_we  = 1'b1;
              else           rdata_d = ram_rd;
            end else begin
              state_d    = ST_WAIT;
              wait_cnt_d = WAIT_INIT;
            end
          end else begin
            // IO and unmapped accesses complete on this edge.
            state_d   = ST_ACK;
            mem_ack_d = 1'b1;
            if (live_is_io) begin
              if (mem_write) begin
                if (mem_addr[3:2] == 2'd0) led_d   = mem_data_write[7:0];
                if (mem_addr[3:2] == 2'd3) err_clr = 1'b1;
              end else begin
                rdata_d = io_read(mem_addr[3:2], led_q, sw_sync_q, cycles_q, bus_err_q);
              end
            end else begin
              err_set = 1'b1;
              if (!mem_write) rdata_d = 32'h0;
            end
          end
        end
      end
      ST_WAIT: begin
        if (req_any) err_set = 1'b1;
        if (wait_cnt_q == 4'd0) begin
          state_d   = ST_ACK;
          mem_ack_d = 1'b1;
          if (req_wr_q) ram_we  = 1'b1;
          else          rdata_d = ram_rd;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        if (req_any) err_set = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new error in the same cycle as an ERR write keeps the flag set.
    if (err_set)      bus_err_d = 1'b1;
    else if (err_clr) bus_err_d = 1'b0;
    else              bus_err_d = bus_err_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      mem_ack_q  <= 1'b0;
      rdata_q    <= 32'h0;
      led_q      <= 8'h0;
      bus_err_q  <= 1'b0;
      cycles_q   <= 32'h0;
      sw_meta_q  <= 8'h0;
      sw_sync_q  <= 8'h0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_ack_q  <= mem_ack_d;
      rdata_q    <= rdata_d;
      led_q      <= led_d;
      bus_err_q  <= bus_err_d;
      cycles_q   <= cycles_d;
      sw_meta_q  <= sw_in;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Request capture is pure data: a reset returns the FSM to IDLE, which
  // makes any captured request irrelevant.
  always_ff @(posedge clk) begin
    req_idx_q   <= req_idx_d;
    req_wdata_q <= req_wdata_d;
    req_wr_q    <= req_wr_d;
  end

  // RAM contents survive reset; a write aborted by reset never reaches here.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= ram_wdata;
  end

  assign mem_ack       = mem_ack_q;
  assign mem_data_read = rdata_q;
  assign led_out       = led_q;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_ioctrl.sv
module tb_ioctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_data_write = 32'h0;
  logic        mem_ack;
  logic [31:0] mem_data_read;
  logic [7:0]  sw_in = 8'h0;
  logic [7:0]  led_out;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  ioctrl #(.RAM_WORDS(1024), .RAM_WAIT(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_data_write (mem_data_write),
    .mem_ack        (mem_ack),
    .mem_data_read  (mem_data_read),
    .sw_in          (sw_in),
    .led_out        (led_out),
    .bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] data;
    logic        err;
    logic [7:0]  led;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called right after the sampling edge; returns the number of edges from
  // that edge to the one where mem_ack is seen (bounded).
  task automatic wait_ack(output int lat);
    lat = 1;
    @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_addr = $urandom;
    mem_data_write = $urandom;
    while (mem_ack !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdata, output int lat);
    @(negedge clk);
    mem_read = rd;
    mem_write = wr;
    mem_addr = a;
    mem_data_write = d;
    @(posedge clk);
    wait_ack(lat);
    rdata = mem_data_read;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata;
    logic [31:0] c1;
    logic [31:0] c2;
    int lat;
    int acks;

    //              rd    wr    addr          wdata         lat data          err   led
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 3, 32'h0000_0000, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         3, 32'hCAFE_F00D, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 32'h8000_0000, 32'h0000_01A5, 1, 32'hCAFE_F00D, 1'b0, 8'hA5};
    vecs[3]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         1, 32'h0000_00A5, 1'b0, 8'hA5};
    vecs[4]  = '{1'b0, 1'b1, 32'h8000_0004, 32'h0000_00FF, 1, 32'h0000_00A5, 1'b0, 8'hA5};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h1234_5678, 3, 32'h0000_00A5, 1'b0, 8'hA5};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0017, 32'h0,         3, 32'h1234_5678, 1'b0, 8'hA5};
    vecs[7]  = '{1'b0, 1'b1, 32'h8000_0008, 32'h0,         1, 32'h1234_5678, 1'b0, 8'hA5};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF, 3, 32'h1234_5678, 1'b0, 8'hA5};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         3, 32'hDEAD_BEEF, 1'b0, 8'hA5};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         1, 32'h0000_0000, 1'b1, 8'hA5};
    vecs[11] = '{1'b1, 1'b0, 32'h8000_000C, 32'h0,         1, 32'h0000_0001, 1'b1, 8'hA5};
    vecs[12] = '{1'b0, 1'b1, 32'h8000_000C, 32'h5555_5555, 1, 32'h0000_0001, 1'b0, 8'hA5};
    vecs[13] = '{1'b1, 1'b0, 32'h8000_000C, 32'h0,         1, 32'h0000_0000, 1'b0, 8'hA5};
    vecs[14] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0,         1, 32'h0000_0000, 1'b1, 8'hA5};
    vecs[15] = '{1'b0, 1'b1, 32'h8000_000C, 32'h0,         1, 32'h0000_0000, 1'b0, 8'hA5};
    vecs[16] = '{1'b0, 1'b1, 32'h8000_0000, 32'h0000_005A, 1, 32'h0000_0000, 1'b0, 8'h5A};
    vecs[17] = '{1'b0, 1'b1, 32'h4000_0000, 32'h0000_0077, 1, 32'h0000_0000, 1'b1, 8'h5A};
    vecs[18] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         1, 32'h0000_005A, 1'b1, 8'h5A};
    vecs[19] = '{1'b0, 1'b1, 32'h8000_000C, 32'h0,         1, 32'h0000_005A, 1'b0, 8'h5A};
    vecs[20] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         3, 32'hCAFE_F00D, 1'b0, 8'h5A};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'b0, mem_ack}, 32'h0);
    check("rst_data", mem_data_read, 32'h0);
    check("rst_led", {24'b0, led_out}, 32'h0);
    check("rst_err", {31'b0, bus_err}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, lat);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_data", i), rdata, vecs[i].data);
      check($sformatf("v%0d_err", i), {31'b0, bus_err}, {31'b0, vecs[i].err});
      check($sformatf("v%0d_led", i), {24'b0, led_out}, {24'b0, vecs[i].led});
      @(negedge clk);
      check($sformatf("v%0d_ack_pulse", i), {31'b0, mem_ack}, 32'h0);
    end

    // Switch synchronizer
    sw_in = 8'h3C;
    repeat (3) @(posedge clk);
    access(1'b1, 1'b0, 32'h8000_0004, 32'h0, rdata, lat);
    check("sw_read", rdata, 32'h0000_003C);

    // Two CYCLES reads ten edges apart
    access(1'b1, 1'b0, 32'h8000_0008, 32'h0, c1, lat);
    repeat (9) @(posedge clk);
    access(1'b1, 1'b0, 32'h8000_0008, 32'h0, c2, lat);
    check("cycles_diff", c2 - c1, 32'd10);

    // CYCLES wrap: counter placed just below the top
    @(negedge clk);
    dut.cycles_q = 32'hFFFF_FFFA;
    access(1'b1, 1'b0, 32'h8000_0008, 32'h0, c1, lat);
    check("cycles_pre_wrap", c1, 32'hFFFF_FFFB);
    repeat (9) @(posedge clk);
    access(1'b1, 1'b0, 32'h8000_0008, 32'h0, c2, lat);
    check("cycles_wrapped", c2, 32'h0000_0005);

    // Second request arriving during WAIT is ignored and flagged
    @(negedge clk);
    mem_read = 1'b1;
    mem_addr = 32'h0000_0010;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b1;
    mem_addr = 32'h8000_0000;
    @(posedge clk);
    wait_ack(lat);
    check("busy_lat", 32'(lat), 32'd2);
    check("busy_data", mem_data_read, 32'hCAFE_F00D);
    check("busy_err", {31'b0, bus_err}, 32'h1);
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_ack === 1'b1) acks++;
    end
    check("busy_no_extra_ack", 32'(acks), 32'd0);
    access(1'b0, 1'b1, 32'h8000_000C, 32'h0, rdata, lat);
    check("busy_err_clear", {31'b0, bus_err}, 32'h0);

    // Read and write together: write wins, error flagged
    access(1'b1, 1'b1, 32'h0000_0018, 32'h0000_ABCD, rdata, lat);
    check("rw_ram_lat", 32'(lat), 32'd3);
    check("rw_ram_err", {31'b0, bus_err}, 32'h1);
    check("rw_ram_data_hold", rdata, 32'hCAFE_F00D);
    access(1'b0, 1'b1, 32'h8000_000C, 32'h0, rdata, lat);
    access(1'b1, 1'b0, 32'h0000_0018, 32'h0, rdata, lat);
    check("rw_ram_readback", rdata, 32'h0000_ABCD);
    check("rw_ram_err_after", {31'b0, bus_err}, 32'h0);
    access(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0033, rdata, lat);
    check("rw_io_lat", 32'(lat), 32'd1);
    check("rw_io_led", {24'b0, led_out}, 32'h33);
    check("rw_io_err", {31'b0, bus_err}, 32'h1);

    // Reset during the WAIT of a write
    access(1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, rdata, lat);
    check("pre_rst_err", {31'b0, bus_err}, 32'h1);
    @(negedge clk);
    mem_write = 1'b1;
    mem_addr = 32'h0000_0020;
    mem_data_write = 32'h0000_1234;
    @(posedge clk);
    @(negedge clk);
    mem_write = 1'b0;
    mem_addr = 32'h0;
    reset_n = 1'b0;
    #1;
    check("arst_ack", {31'b0, mem_ack}, 32'h0);
    check("arst_data", mem_data_read, 32'h0);
    check("arst_led", {24'b0, led_out}, 32'h0);
    check("arst_err", {31'b0, bus_err}, 32'h0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_ack === 1'b1) acks++;
    end
    // Request presented with the release so the first edge samples it
    reset_n = 1'b1;
    mem_read = 1'b1;
    mem_addr = 32'h0000_0020;
    @(posedge clk);
    wait_ack(lat);
    check("arst_no_ack", 32'(acks), 32'd0);
    check("arst_first_lat", 32'(lat), 32'd3);
    check("arst_ram_kept", mem_data_read, 32'h1111_1111);
    // Counter restarted at 0 on that first edge; this read samples at its 4th
    access(1'b1, 1'b0, 32'h8000_0008, 32'h0, rdata, lat);
    check("arst_cycles", rdata, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ioctrl.md
IOCTRL -- requirements
Module: ioctrl

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, internal RAM depth in 32-bit words (power of two).
REQ-002 SHALL have parameter RAM_WAIT, default 2, extra wait cycles for RAM accesses (0..15).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port mem_read, input, 1, read request pulse.
REQ-006 SHALL have port mem_write, input, 1, write request pulse.
REQ-007 SHALL have port mem_addr, input, 32, byte address; bits [1:0] ignored.
REQ-008 SHALL have port mem_data_write, input, 32, write data.
REQ-009 SHALL have port mem_ack, output, 1, registered one-cycle completion pulse.
REQ-010 SHALL have port mem_data_read, output, 32, registered read data.
REQ-011 SHALL have port sw_in, input, 8, asynchronous switch inputs.
REQ-012 SHALL have port led_out, output, 8, registered LED register.
REQ-013 SHALL have port bus_err, output, 1, sticky error flag.

Function
REQ-014 Requests SHALL be single-cycle pulses; addr/data SHALL be latched on the edge that samples the request; inputs SHALL NOT be needed afterwards.
REQ-015 FSM states SHALL be IDLE, WAIT, ACK; requests SHALL be sampled only in IDLE.
REQ-016 Request sampled at edge T0: IO access SHALL enter ACK at T0+1; RAM access SHALL enter WAIT for RAM_WAIT cycles (skipped if 0), then ACK at T0+1+RAM_WAIT.
REQ-017 mem_ack SHALL be 1 for exactly the ACK cycle; ACK SHALL return to IDLE on the next edge.
REQ-018 mem_data_read SHALL be valid while mem_ack=1 and hold its value until the next read ack; write acks SHALL NOT change it.
REQ-019 Writes SHALL commit on the edge entering ACK.
REQ-020 mem_read and mem_write both 1 in IDLE: write SHALL win, read dropped, bus_err set.
REQ-021 Request sampled in WAIT or ACK SHALL be ignored (no ack) and set bus_err.
REQ-022 Map: addr[31]=0 and addr < RAM_WORDS*4 -> RAM word addr[log2(RAM_WORDS)+1:2].
REQ-023 Map: addr[31]=1, addr[30:4]=0: addr[3:2]=0 LED (RW, bits[7:0], read zero-extended); 1 SW (RO); 2 CYCLES (RO); 3 ERR (read {31'b0,bus_err}, any write clears).
REQ-024 Unmapped address SHALL take IO latency, return 32'h0 on read, discard writes, set bus_err.
REQ-025 Writes to SW/CYCLES SHALL be acked and discarded without error.
REQ-026 CYCLES SHALL be a free-running 32-bit counter, +1 per clock, wrapping 32'hFFFF_FFFF -> 0; read returns value at the sampling edge T0.
REQ-027 sw_in SHALL pass a 2-flop synchronizer; SW read returns synchronized value zero-extended.
REQ-028 bus_err set and ERR-write clear in the same cycle: set SHALL win.

Reset
REQ-029 reset_n=0 SHALL asynchronously force IDLE, mem_ack=0, mem_data_read=0, led_out=0, bus_err=0, CYCLES=0, synchronizer=0.
REQ-030 Reset mid-access SHALL abort it with no ack; pending write SHALL NOT commit; RAM contents not reset.
REQ-031 First request SHALL be sampled on the first edge after reset_n deasserts.

Verification (RAM_WAIT=2)
REQ-032 Write 0x0000_0010=0xCAFE_F00D at T0 -> ack at T0+3; read same at T1 -> ack at T1+3 with 0xCAFE_F00D.
REQ-033 Write 0x8000_0000=0x1A5 -> led_out=0xA5 after ack at T0+1; read -> 0x0000_00A5; sw_in=0x3C stable 3 cycles, read 0x8000_0004 -> 0x0000_003C.
REQ-034 Read 0x8000_0008 twice, second request 10 cycles after first -> values differ by exactly 10; preload near 32'hFFFF_FFFF via reset timing -> wraps to 0.
REQ-035 Read 0x4000_0000 -> ack at T0+1, data 0, bus_err=1; second request during WAIT ignored; write 0x8000_000C -> bus_err=0.
REQ-036 reset_n low during WAIT of write 0x0000_0020=0x1234 -> no ack, later read returns prior contents; mem_read and mem_write together -> write performed, bus_err=1.
